// File: rtl/dtc_seq_pkg.sv
// rtl/dtc_seq_pkg.sv - shared types and constants for the decision-tree sequential walker
// Holds the node entry layout, its field bit positions, the table geometry,
// the optional step limit and the table reset value.
package dtc_seq_pkg;

    localparam int NODE_COUNT = 16;
    localparam int ENTRY_W    = 13;
    localparam int DEPTH_W    = 5;

    localparam logic [DEPTH_W-1:0] STEP_LIMIT = 5'd16;
    localparam logic [ENTRY_W-1:0] LEAF_RESET = 13'h1000;

    // Field bit positions within a node entry
    localparam int IS_LEAF_BIT    = 12;
    localparam int LEAF_CLASS_BIT = 11;
    localparam int FEAT_IDX_HI    = 10;
    localparam int FEAT_IDX_LO    = 8;
    localparam int PTR_ONE_HI     = 7;
    localparam int PTR_ONE_LO     = 4;
    localparam int PTR_ZERO_HI    = 3;
    localparam int PTR_ZERO_LO    = 0;

    typedef struct packed {
        logic       is_leaf;
        logic       leaf_class;
        logic [2:0] feat_idx;
        logic [3:0] ptr_one;
        logic [3:0] ptr_zero;
    } node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } walk_state_t;

endpackage

// File: rtl/dtc_seq_walker_if.sv
// rtl/dtc_seq_walker_if.sv - config, sample and result handshake bundle for the walker
// Signals: cfg_we/cfg_addr/cfg_data/cfg_ready (table write port),
// in_valid/in_ready/in_sample (sample input), out_valid/out_ready/out_class/
// out_depth/out_err (classification result). slave = walker side.
interface dtc_seq_walker_if;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [12:0] cfg_data;
    logic        cfg_ready;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sample;
    logic        out_valid;
    logic        out_ready;
    logic        out_class;
    logic [4:0]  out_depth;
    logic        out_err;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_sample, out_ready,
        output cfg_ready, in_ready, out_valid, out_class, out_depth, out_err
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_sample, out_ready,
        input  cfg_ready, in_ready, out_valid, out_class, out_depth, out_err
    );
endinterface

// File: rtl/dtc_node_table.sv
// rtl/dtc_node_table.sv - 16x13 node register file, synchronous write, asynchronous read
// Ports: clk, rst_n (sync, active low, loads LEAF_RESET into every entry),
// we/waddr/wdata (write port), raddr/rdata (combinational read port).
module dtc_node_table
    import dtc_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [3:0]         waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [3:0]         raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [NODE_COUNT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                mem[i] <= LEAF_RESET;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dtc_seq_walker.sv
// rtl/dtc_seq_walker.sv - walks a programmable binary decision tree one node per cycle
// Ports: clk, rst_n (sync, active low), bus (dtc_seq_walker_if.slave) carrying
// the table write port, the sample input and the classification result.
// Build option: DTC_STEP_LIMIT_EN aborts a walk that reaches depth 16 with
// out_err=1; without it out_err is tied low and a cyclic table walks forever.
module dtc_seq_walker
    import dtc_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    dtc_seq_walker_if.slave bus
);

    walk_state_t        state;
    logic [3:0]         ptr;
    logic [DEPTH_W-1:0] depth;
    logic [7:0]         sample;
    logic               out_valid_q;
    logic               out_class_q;
    logic [DEPTH_W-1:0] out_depth_q;
    logic [ENTRY_W-1:0] rdata;
    node_t              entry;
    logic               table_we;

    // Writes only land while idle, so a walk always sees a frozen table.
    assign table_we = bus.cfg_we && (state == IDLE);

    dtc_node_table u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (table_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (ptr),
        .rdata (rdata)
    );

    assign entry = node_t'(rdata);

`ifdef DTC_STEP_LIMIT_EN
    logic out_err_q;
    assign bus.out_err = out_err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            depth       <= '0;
            sample      <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= 1'b0;
            out_depth_q <= '0;
`ifdef DTC_STEP_LIMIT_EN
            out_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sample <= bus.in_sample;
                        ptr    <= '0;
                        depth  <= '0;
                        state  <= WALK;
                    end
                end
                WALK: begin
                    if (entry.is_leaf) begin
                        out_class_q <= entry.leaf_class;
                        out_depth_q <= depth;
                        out_valid_q <= 1'b1;
`ifdef DTC_STEP_LIMIT_EN
                        out_err_q   <= 1'b0;
`endif
                        state       <= DONE;
`ifdef DTC_STEP_LIMIT_EN
                    end else if (depth == STEP_LIMIT) begin
                        // Still on an internal node after the limit: give up.
                        out_class_q <= 1'b0;
                        out_depth_q <= depth;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        state       <= DONE;
`endif
                    end else begin
                        ptr   <= sample[entry.feat_idx] ? entry.ptr_one : entry.ptr_zero;
                        depth <= depth + 5'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.cfg_ready = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_depth = out_depth_q;

endmodule

// File: tb/tb_dtc_seq_walker.sv
// tb/tb_dtc_seq_walker.sv - randomized self-checking bench for dtc_seq_walker
module tb_dtc_seq_walker;
    import dtc_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dtc_seq_walker_if bus ();

    dtc_seq_walker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [12:0] tbl [16];
    int obs_cls, obs_dep, obs_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows pointers through the table model until a leaf, the limit, or a hang.
    function automatic void ref_walk(input logic [7:0] s, output int cls, output int dep,
                                     output int err, output bit hang);
        int p;
        logic [12:0] e;
        p = 0; dep = 0; cls = 0; err = 0; hang = 0;
        forever begin
            e = tbl[p];
            if (e[12]) begin
                cls = int'(e[11]);
                return;
            end
`ifdef DTC_STEP_LIMIT_EN
            if (dep == 16) begin
                err = 1;
                cls = 0;
                return;
            end
`endif
            if (dep >= 200) begin
                hang = 1;
                return;
            end
            p = s[e[10:8]] ? int'(e[7:4]) : int'(e[3:0]);
            dep++;
        end
    endfunction

    function automatic logic [12:0] gen_entry(input int i);
        logic [12:0] e;
        e = 13'($urandom);
        if (i == 15 || $urandom_range(0, 2) == 0) begin
            e[12] = 1'b1;
        end else begin
            e[12] = 1'b0;
            e[7:4] = 4'($urandom_range(i + 1, 15));
            e[3:0] = 4'($urandom_range(i + 1, 15));
        end
        return e;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 16; i++) tbl[i] = 13'h1000;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [12:0] d);
        chk("cfg_ready", bus.cfg_ready, 1);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        tick();
        bus.cfg_we = 1'b0;
        tbl[a] = d;
    endtask

    // cfg_mode: 0 none, 1 write together with accept, 2 write attempt during the walk
    task automatic do_query(input logic [7:0] s, input int cfg_mode, input logic [3:0] ca,
                            input logic [12:0] cd, input int hold);
        int cls, dep, err, n;
        bit hang;
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_sample = s;
        if (cfg_mode == 1) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = ca; bus.cfg_data = cd;
            tbl[ca] = cd;
        end
        ref_walk(s, cls, dep, err, hang);
        tick();
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0; bus.in_sample = 8'($urandom);
        if (cfg_mode == 2) begin
            chk("cfg_ready_busy", bus.cfg_ready, 0);
            bus.cfg_we = 1'b1; bus.cfg_addr = ca; bus.cfg_data = cd;
        end
        n = 0;
        do begin
            tick();
            bus.cfg_we = 1'b0;
            n++;
        end while (!bus.out_valid && n < 40);
        chk("out_valid", bus.out_valid, 1);
        chk("latency", n, dep + 1);
        chk("class", bus.out_class, cls);
        chk("depth", bus.out_depth, dep);
        chk("err", bus.out_err, err);
        chk("in_ready_done", bus.in_ready, 0);
        obs_cls = int'(bus.out_class); obs_dep = int'(bus.out_depth); obs_err = int'(bus.out_err);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_class", bus.out_class, cls);
            chk("hold_depth", bus.out_depth, dep);
            chk("hold_err", bus.out_err, err);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("valid_drop", bus.out_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
    endtask

    initial begin
        int seen;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b0;
        reset_model();
        tick(); tick();
        rst_n = 1'b1;

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_class", bus.out_class, 0);
        chk("rst_depth", bus.out_depth, 0);
        chk("rst_err", bus.out_err, 0);

        bus.out_ready = 1'b1;
        do_query(8'hA5, 0, 4'd0, 13'd0, 0);
        chk("a5_class", obs_cls, 0);
        chk("a5_depth", obs_dep, 0);

        cfg_write(4'd0, 13'h0421);
        cfg_write(4'd1, 13'h0243);
        cfg_write(4'd2, 13'h0765);
        cfg_write(4'd3, 13'h1800);
        cfg_write(4'd4, 13'h0078);
        cfg_write(4'd5, 13'h0378);
        cfg_write(4'd6, 13'h1000);
        cfg_write(4'd7, 13'h1000);
        cfg_write(4'd8, 13'h1800);

        do_query(8'h00, 0, 4'd0, 13'd0, 0);
        chk("t00_class", obs_cls, 1); chk("t00_depth", obs_dep, 2);
        do_query(8'h05, 0, 4'd0, 13'd0, 5);
        chk("t05_class", obs_cls, 0); chk("t05_depth", obs_dep, 3);
        do_query(8'h10, 0, 4'd0, 13'd0, 0);
        chk("t10_class", obs_cls, 1); chk("t10_depth", obs_dep, 3);
        do_query(8'h98, 0, 4'd0, 13'd0, 2);
        chk("t98_class", obs_cls, 0); chk("t98_depth", obs_dep, 2);

        // Write to node0 during a walk must be dropped.
        do_query(8'h10, 2, 4'd0, 13'h1800, 0);
        do_query(8'h00, 0, 4'd0, 13'd0, 0);
        chk("ro_class", obs_cls, 1); chk("ro_depth", obs_dep, 2);

        // Reset at depth 2 of a depth-3 walk.
        bus.in_valid = 1'b1; bus.in_sample = 8'h05;
        tick();
        bus.in_valid = 1'b0;
        tick(); chk("mid_valid1", bus.out_valid, 0);
        tick(); chk("mid_valid2", bus.out_valid, 0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_depth", bus.out_depth, 0);
        rst_n = 1'b1;
        reset_model();
        tick();
        chk("post_rst_valid", bus.out_valid, 0);
        do_query(8'h05, 0, 4'd0, 13'd0, 0);
        chk("post_rst_class", obs_cls, 0); chk("post_rst_depth", obs_dep, 0);

        // Random acyclic tables and samples, some with a write alongside the accept.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) cfg_write(4'(i), gen_entry(i));
            for (int q = 0; q < 6; q++) begin
                int a;
                a = $urandom_range(0, 15);
                do_query(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, 4'(a),
                         gen_entry(a), $urandom_range(0, 3));
            end
        end

        // Self-loop on node0.
        cfg_write(4'd0, 13'h0000);
`ifdef DTC_STEP_LIMIT_EN
        do_query(8'($urandom), 0, 4'd0, 13'd0, 0);
        chk("loop_err", obs_err, 1); chk("loop_depth", obs_dep, 16); chk("loop_class", obs_cls, 0);
`else
        bus.in_valid = 1'b1; bus.in_sample = 8'($urandom);
        tick();
        bus.in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("loop_no_valid", seen, 0);
        chk("loop_busy", bus.in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("loop_rst_idle", bus.in_ready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtc_seq_walker.md
DTC_SEQ_WALKER -- requirements
Module: dtc_seq_walker

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-002 SHALL have: cfg_we input 1, node-table write strobe; cfg_addr input 4, node index; cfg_data input 13, node entry; cfg_ready output 1, write accepted when high.
REQ-003 SHALL have: in_valid input 1; in_ready output 1; in_sample input 8, feature vector.
REQ-004 SHALL have: out_valid output 1; out_ready input 1; out_class output 1; out_depth output 5, internal nodes traversed; out_err output 1, step-limit abort.
REQ-005 Entry format SHALL be: [12] is_leaf; [11] leaf_class; [10:8] feat_idx; [7:4] ptr_one; [3:0] ptr_zero.

Function
REQ-006 FSM states SHALL be IDLE, WALK, DONE.
REQ-007 in_ready and cfg_ready SHALL be high only in IDLE.
REQ-008 cfg_we in IDLE SHALL write cfg_data to entry cfg_addr at the clock edge.
REQ-009 cfg_we outside IDLE SHALL be dropped without side effects.
REQ-010 Accept (in_valid && in_ready at edge T0) SHALL latch in_sample, set ptr=0 and depth=0, and enter WALK.
REQ-011 Each WALK cycle SHALL evaluate one entry, table[ptr], using a combinational read.
REQ-012 Leaf entry: capture leaf_class and depth, enter DONE.
REQ-013 Internal entry: ptr <= sample[feat_idx] ? ptr_one : ptr_zero; depth <= depth+1.
REQ-014 Latency: out_valid SHALL rise at edge T0+d+1, where d is the number of internal nodes traversed.
REQ-015 DONE SHALL hold out_valid=1 and keep out_class, out_depth, and out_err stable until out_valid && out_ready, then return to IDLE.
REQ-016 A new sample SHALL be accepted no earlier than the cycle after handshake completion; there is no overlap.
REQ-017 A simultaneous cfg_we and in_valid in IDLE SHALL perform both; the walk uses the updated table.
REQ-018 A pointer may target any index, including itself; the walker follows it unchanged.

Reset
REQ-019 rst_n low at an edge SHALL force IDLE, out_valid=0, out_class=0, out_depth=0, out_err=0, ptr=0.
REQ-020 Reset SHALL set every table entry to 13'h1000 (leaf, class 0).
REQ-021 Reset mid-WALK or mid-DONE SHALL discard the sample with no out_valid pulse.

Configuration
REQ-022 With DTC_STEP_LIMIT_EN defined, a walk SHALL abort when depth reaches 16 without a leaf: DONE, out_err=1, out_class=0, out_depth=16.
REQ-023 Without DTC_STEP_LIMIT_EN, out_err SHALL be tied 0 and a cyclic table walks until reset.
REQ-024 In both builds, out_depth SHALL remain 5 bits wide.

Structure
REQ-025 Package dtc_seq_pkg SHALL hold the node entry typedef, the field bit positions, NODE_COUNT=16, STEP_LIMIT=16, and LEAF_RESET=13'h1000.
REQ-026 Sub-module dtc_node_table SHALL implement the 16x13 register file: synchronous write, asynchronous read, synchronous reset to LEAF_RESET.

Verification
REQ-027 Post-reset query: in_sample=8'hA5 with out_ready=1 -> out_valid at T0+1, out_class=0, out_depth=0, out_err=0.
REQ-028 Program a three-level tree:
- node0 = internal feat4, ptr_one=2, ptr_zero=1.
- node1 = internal feat2, ptr_one=4, ptr_zero=3.
- node2 = internal feat7, ptr_one=6, ptr_zero=5.
- node3 = leaf 1; node4 = internal feat0, ptr_one=7, ptr_zero=8; node5 = internal feat3, ptr_one=7, ptr_zero=8.
- node6 = leaf 0; node7 = leaf 0; node8 = leaf 1.
- Response: sample 8'h00 -> class 1, depth 2; sample 8'h05 -> class 0, depth 3; sample 8'h10 -> class 1, depth 3; sample 8'h98 -> class 0, depth 2.
REQ-029 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> in_ready=1 on the next cycle.
REQ-030 Config during WALK: cfg_we to node0 while walking -> write ignored; a subsequent IDLE read-back query shows the old entry.
REQ-031 Self-loop: node0 = internal feat0, ptr_one=0, ptr_zero=0:
- With DTC_STEP_LIMIT_EN -> out_err=1, out_depth=16 at T0+17.
- Without it -> no out_valid for 100 cycles.
REQ-032 Assert rst_n=0 during depth 2 of a walk -> IDLE next cycle, no out_valid, table reads LEAF_RESET.
